hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage MIPS-32 pipeline.
- Consumes register indices and control bits from the D, E, M and W stages.
- Produces the stall/flush enables that drive the pipeline registers, plus the forwarding-mux selects for D and E.
- Owns a multi-cycle divide-stall FSM that freezes F/D/E while the iterative divider runs.

---
 rtl/hazard_ctrl_pkg.sv | 36 +++
 rtl/hazard_ctrl_div.sv | 76 +++++++
 rtl/hazard_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared constants and types for the hazard controller
// Purpose: forwarding-select encodings, divide-stall FSM state type and the
//          forwarding-select helper shared by hazard_ctrl.
// Ports:   none (package).
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // M beats W because M holds the younger result; r0 is hard-wired zero
    // and must never be forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic       regwrite_m,
        input logic [4:0] writereg_m,
        input logic       regwrite_w,
        input logic [4:0] writereg_w,
        input logic [4:0] src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (regwrite_m && (writereg_m != 5'd0) && (writereg_m == src)) begin
            sel = FWD_M;
        end else if (regwrite_w && (writereg_w != 5'd0) && (writereg_w == src)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_div.sv
// rtl/hazard_ctrl_div.sv - divide-stall FSM for the hazard controller
// Purpose: tracks the iterative divider and raises div_busy while it runs.
// Ports:   clk, reset (async, active-high), divE (DIV/DIVU in E),
//          flush_exc (abort), div_busy (divider running, combinational start).
module div_stall_fsm
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic divE,
    input  logic flush_exc,
    output logic div_busy
);

    // The IDLE cycle in which divE is first seen already counts as one busy
    // cycle, so BUSY only has to cover the remaining DIV_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        div_busy    = 1'b0;
        case (r_state)
            IDLE: begin
                if (divE) begin
                    div_busy = 1'b1;
                    if (!flush_exc) begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                div_busy  = 1'b1;
                w_cnt_nxt = r_cnt - CNT_ONE;
                // Leave when the decrement reaches zero.
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end
            end
            DONE: begin
                // The finished DIV is still in E here, so divE is ignored.
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (flush_exc) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard and forwarding controller for the 5-stage MIPS-32 pipeline
// Purpose: forwarding selects for D and E, load-use / branch stalls, divide
//          stall via div_stall_fsm, exception flush override.
// Ports:   clk, reset (async, active-high); D/E/M/W register indices and
//          control bits in; stallF/D/E, flushD/E, forwardaD/bD (1b),
//          forwardaE/bE (2b: 00 regfile, 01 W, 10 M), div_busy out.
// Config:  HAZARD_PERF_CNT_EN adds stall_cycles and div_cycles (32b) counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       jrD,
    input  logic       divE,
    input  logic       flush_exc,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       forwardaD,
    output logic       forwardbD,
    output logic [1:0] forwardaE,
    output logic [1:0] forwardbE,
    output logic       div_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] div_cycles
`endif
);

    logic w_div_busy;
    logic w_lwstall;
    logic w_br_e;
    logic w_br_m;
    logic w_branchstall;
    logic w_hazard;

    div_stall_fsm #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .divE      (divE),
        .flush_exc (flush_exc),
        .div_busy  (w_div_busy)
    );

    assign forwardaE = fwd_sel(regwriteM, writeregM, regwriteW, writeregW, rsE);
    assign forwardbE = fwd_sel(regwriteM, writeregM, regwriteW, writeregW, rtE);
    assign forwardaD = regwriteM && (writeregM != 5'd0) && (writeregM == rsD);
    assign forwardbD = regwriteM && (writeregM != 5'd0) && (writeregM == rtD);

    assign w_lwstall = memtoregE && (writeregE != 5'd0)
                    && ((writeregE == rsD) || (writeregE == rtD));

    // A branch compares in D, so it must wait for an ALU result still in E
    // or a load result still in M.
    assign w_br_e = regwriteE && (writeregE != 5'd0)
                 && ((writeregE == rsD) || (writeregE == rtD));
    assign w_br_m = memtoregM && (writeregM != 5'd0)
                 && ((writeregM == rsD) || (writeregM == rtD));
    assign w_branchstall = (branchD || jrD) && (w_br_e || w_br_m);

    assign w_hazard = w_lwstall || w_branchstall;

    // flush_exc wins over every stall; during a divide E is held, not bubbled.
    assign stallF   = !flush_exc && (w_hazard || w_div_busy);
    assign stallD   = stallF;
    assign stallE   = !flush_exc && w_div_busy;
    assign flushD   = flush_exc;
    assign flushE   = flush_exc || (w_hazard && !w_div_busy);
    assign div_busy = w_div_busy;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_div_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_div_cycles   <= '0;
        end else begin
            if (stallD) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_div_busy) begin
                r_div_cycles <= r_div_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign div_cycles   = r_div_cycles;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int DIV_CYCLES = 4;
    localparam int CNT_W      = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, jrD, divE, flush_exc;
    logic       stallF, stallD, stallE, flushD, flushE, forwardaD, forwardbD, div_busy;
    logic [1:0] forwardaE, forwardbE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, div_cycles;
    logic [31:0] m_stall_cnt, m_div_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference divide model: cycles of busy still owed after the current
    // one, plus a flag for the single post-divide cycle.
    int m_left = 0;
    bit m_done = 1'b0;

    hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jrD(jrD), .divE(divE), .flush_exc(flush_exc),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .div_busy(div_busy)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .div_cycles(div_cycles)
`endif
    );

    always #5 clk = ~clk;

    wire [11:0] obs = {stallF, stallD, stallE, flushD, flushE, forwardaD, forwardbD,
                       forwardaE, forwardbE, div_busy};

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (regwriteM && writeregM != 0 && writeregM == src) return 2'b10;
        if (regwriteW && writeregW != 0 && writeregW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [11:0] m_expect();
        logic lw, br, busy, hz, sF, sE, fD, fE, faD, fbD;
        lw   = memtoregE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
        br   = (branchD || jrD) &&
               ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
                (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
        busy = (m_left > 0) || (!m_done && divE);
        hz   = lw || br;
        sF   = flush_exc ? 1'b0 : (hz || busy);
        sE   = flush_exc ? 1'b0 : busy;
        fD   = flush_exc;
        fE   = flush_exc ? 1'b1 : (hz && !busy);
        faD  = regwriteM && writeregM != 0 && writeregM == rsD;
        fbD  = regwriteM && writeregM != 0 && writeregM == rtD;
        return {sF, sF, sE, fD, fE, faD, fbD, m_fwd(rsE), m_fwd(rtE), busy};
    endfunction

    task automatic clear_inputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
        {branchD, jrD, divE, flush_exc} = '0;
    endtask

    task automatic model_reset();
        m_left = 0;
        m_done = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        m_stall_cnt = '0;
        m_div_cnt   = '0;
`endif
    endtask

    // Advance one clock, updating the model with the inputs seen at the edge.
    task automatic tick();
        logic [11:0] e;
        e = m_expect();
        @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
        if (e[10]) m_stall_cnt = m_stall_cnt + 1;
        if (e[0])  m_div_cnt   = m_div_cnt + 1;
`endif
        if (flush_exc) begin
            m_left = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1'b1;
        end else if (e[0]) begin
            m_left = DIV_CYCLES - 1;
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (obs !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 12'd0);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if (stall_cycles !== 32'd0 || div_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", stall_cycles, div_cycles);
        end
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_forwarding();
        clear_inputs();
        regwriteM = 1; writeregM = 8; regwriteW = 1; writeregW = 8; rsE = 8; rtE = 8;
        @(negedge clk);
        n_checks++;
        if (forwardaE !== 2'b10 || forwardbE !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_m_priority: got %b/%b expected 10/10", forwardaE, forwardbE);
        end
        tick();
        regwriteM = 0;
        @(negedge clk);
        n_checks++;
        if (forwardaE !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_w: got %b expected 01", forwardaE);
        end
        tick();
        regwriteM = 1; writeregM = 0; writeregW = 0; rsE = 0; rtE = 0;
        @(negedge clk);
        n_checks++;
        if (forwardaE !== 2'b00 || forwardbE !== 2'b00 || forwardaD !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_r0: got %b/%b/%b expected 00/00/0", forwardaE, forwardbE, forwardaD);
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        memtoregE = 1; writeregE = 9; rtD = 9;
        @(negedge clk);
        n_checks++;
        if ({stallF, stallD, flushE} !== 3'b111) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b expected 111", {stallF, stallD, flushE});
        end
        tick();
        memtoregE = 0;
        @(negedge clk);
        n_checks++;
        if (obs !== 12'd0) begin
            n_fail++;
            $display("FAIL load_use_clear: got %b expected %b", obs, 12'd0);
        end
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4;
        @(negedge clk);
        n_checks++;
        if ({stallD, flushE} !== 2'b11) begin
            n_fail++;
            $display("FAIL branch_e_stall: got %b expected 11", {stallD, flushE});
        end
        tick();
        regwriteE = 0; writeregE = 0; memtoregM = 1; regwriteM = 1; writeregM = 4;
        @(negedge clk);
        n_checks++;
        if ({stallD, flushE} !== 2'b11) begin
            n_fail++;
            $display("FAIL branch_m_load_stall: got %b expected 11", {stallD, flushE});
        end
        tick();
        memtoregM = 0;
        @(negedge clk);
        n_checks++;
        if ({forwardaD, stallD, flushE} !== 3'b100) begin
            n_fail++;
            $display("FAIL branch_fwd: got %b expected 100", {forwardaD, stallD, flushE});
        end
        tick();
    endtask

    task automatic test_divide();
        do_reset();
        divE = 1;
        for (int i = 0; i < DIV_CYCLES; i++) begin
            @(negedge clk);
            n_checks++;
            if ({div_busy, stallE, flushE} !== 3'b110) begin
                n_fail++;
                $display("FAIL div_busy_c%0d: got %b expected 110", i, {div_busy, stallE, flushE});
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if ({div_busy, stallE, flushE} !== 3'b000) begin
            n_fail++;
            $display("FAIL div_done: got %b expected 000", {div_busy, stallE, flushE});
        end
        tick();
        divE = 0;
        @(negedge clk);
        n_checks++;
        if (obs !== m_expect()) begin
            n_fail++;
            $display("FAIL div_idle: got %b expected %b", obs, m_expect());
        end
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if (div_cycles !== 32'd4 || stall_cycles !== 32'd4) begin
            n_fail++;
            $display("FAIL perf_after_div: got %0d/%0d expected 4/4", div_cycles, stall_cycles);
        end
`endif
        tick();
    endtask

    task automatic test_abort();
        clear_inputs();
        divE = 1;
        tick();
        divE = 0;
        tick();
        flush_exc = 1;
        @(negedge clk);
        n_checks++;
        if ({flushD, flushE, stallF, stallD, stallE} !== 5'b11000) begin
            n_fail++;
            $display("FAIL abort_flush: got %b expected 11000", {flushD, flushE, stallF, stallD, stallE});
        end
        tick();
        flush_exc = 0;
        @(negedge clk);
        n_checks++;
        if (div_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got %b expected 0", div_busy);
        end
        tick();
        divE = 1;
        tick();
        divE = 0;
        tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got %b expected %b", obs, 12'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== m_expect()) begin
            n_fail++;
            $display("FAIL after_reset: got %b expected %b", obs, m_expect());
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rsD = 5'($urandom_range(0, 3));
            rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3));
            rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            regwriteE = 1'($urandom_range(0, 1));
            regwriteM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1));
            memtoregE = ($urandom_range(0, 3) == 0);
            memtoregM = ($urandom_range(0, 3) == 0);
            branchD   = ($urandom_range(0, 2) == 0);
            jrD       = ($urandom_range(0, 7) == 0);
            divE      = ($urandom_range(0, 5) == 0);
            flush_exc = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            n_checks++;
            if (obs !== m_expect()) begin
                n_fail++;
                $display("FAIL random_c%0d: got %b expected %b", i, obs, m_expect());
            end
`ifdef HAZARD_PERF_CNT_EN
            n_checks++;
            if (stall_cycles !== m_stall_cnt || div_cycles !== m_div_cnt) begin
                n_fail++;
                $display("FAIL random_perf_c%0d: got %0d/%0d expected %0d/%0d",
                         i, stall_cycles, div_cycles, m_stall_cnt, m_div_cnt);
            end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_divide();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
